// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a first-word-fall-through byte FIFO.
// The command parser drains the FIFO with pop. Frame errors and overruns are reported as 1-clk pulses.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       pop,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Oversampling tick: one pulse every DIV clocks.
  logic [TW-1:0] tick_cnt_reg;
  logic          tick;

  assign tick = (tick_cnt_reg == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  // Two-flop synchroniser, preset to the idle-high line level.
  logic [1:0] sync_reg;
  logic       rxs;

  assign rxs = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  logic [1:0] state_reg, state_next;
  logic [3:0] sample_cnt_reg, sample_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       push_reg, push_next;
  logic       frame_err_reg, frame_err_next;

  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    push_next       = 1'b0;
    frame_err_next  = 1'b0;
    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (!rxs) begin
            state_next      = S_START;
            sample_cnt_next = 4'd0;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit so short glitches are rejected.
          if (sample_cnt_reg == 4'd7) begin
            if (!rxs) begin
              state_next      = S_DATA;
              sample_cnt_next = 4'd0;
              bit_cnt_next    = 3'd0;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 4'd1;
          end
        end
        S_DATA: begin
          if (sample_cnt_reg == 4'd15) begin
            shift_next[bit_cnt_reg] = rxs;
            sample_cnt_next         = 4'd0;
            bit_cnt_next            = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next = S_STOP;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 4'd1;
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (sample_cnt_reg == 4'd15) begin
            if (rxs) begin
              push_next = 1'b1;
            end else begin
              frame_err_next = 1'b1;
            end
            state_next      = S_IDLE;
            sample_cnt_next = 4'd0;
          end else begin
            sample_cnt_next = sample_cnt_reg + 4'd1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      push_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      push_reg       <= push_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign rx_busy   = (state_reg != S_IDLE);
  assign frame_err = frame_err_reg;

  // Byte FIFO: combinational head read, so rx_data is valid as soon as rx_empty drops.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          overrun_reg, overrun_next;
  logic          pop_ok, push_ok;

  assign rx_empty = (count_reg == '0);
  assign rx_full  = (count_reg == CW'(FIFO_DEPTH));
  assign rx_data  = mem[rd_ptr_reg];

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign pop_ok       = pop && !rx_empty;
  assign push_ok      = push_reg && (!rx_full || pop_ok);
  assign overrun_next = push_reg && rx_full && !pop_ok;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  // shift_reg is stable until the next frame's first data sample, long after this write.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  assign overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table-driven frames, hand-written corner sequences and
// randomized frames with baud mismatch, checked against a queue model of the byte stream.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = 160;
  // Write edge relative to the start-bit drive: 2 sync flops + up to one tick to detect,
  // then 152 ticks (8 + 9*16) to mid stop bit, plus one or two clocks to the FIFO write.
  localparam int LAT_LO   = 1524;
  localparam int LAT_HI   = 1534;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       pop = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, rx_busy, frame_err, overrun;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .pop(pop), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // Pulse/edge monitor, sampled on the falling edge.
  int ferr_cnt = 0, ferr_wide = 0, ovr_cnt = 0, ovr_wide = 0;
  bit busy_seen = 0;
  logic prev_ferr = 0, prev_ovr = 0, prev_empty = 1, prev_full = 0;
  int unsigned fall_cyc = 0, full_cyc = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      ferr_cnt++;
      if (prev_ferr) ferr_wide++;
    end
    if (overrun === 1'b1) begin
      ovr_cnt++;
      if (prev_ovr) ovr_wide++;
    end
    if (rx_busy === 1'b1) busy_seen = 1;
    if (prev_empty === 1'b1 && rx_empty === 1'b0) fall_cyc = cyc;
    if (prev_full === 1'b0 && rx_full === 1'b1) full_cyc = cyc;
    prev_ferr  = (frame_err === 1'b1);
    prev_ovr   = (overrun === 1'b1);
    prev_empty = (rx_empty !== 1'b0);
    prev_full  = (rx_full === 1'b1);
  end

  // Reference model: the ordered byte stream the FIFO should hold, plus pulse totals.
  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int unsigned start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int blen);
    busy_seen = 0;
    start_cyc = cyc;
    rx = 1'b0;
    repeat (blen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (blen) @(negedge clk);
    end
    rx = stop;
    repeat (blen) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) exp_ferr++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr++;
  endtask

  task automatic do_pop(input string name);
    check({name, "_nonempty"}, rx_empty, 1'b0);
    check({name, "_head"}, rx_data, exp_q[0]);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    void'(exp_q.pop_front());
    check({name, "_empty_after"}, rx_empty, (exp_q.size() == 0));
  endtask

  int pick_blen;
  function automatic int rand_blen();
    case ($urandom_range(0, 2))
      0: rand_blen = 157;
      1: rand_blen = 160;
      default: rand_blen = 163;
    endcase
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
  } vec_t;

  vec_t vecs [5];

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int off;
    logic [7:0] d;
    logic stop;

    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1};

    // Reset and idle.
    rst = 1'b0; rx = 1'b1; pop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", rx_empty, 1'b1);
    check("rst_full", rx_full, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    busy_seen = 0;
    repeat (1000) @(negedge clk);
    check("idle_empty", rx_empty, 1'b1);
    check("idle_busy_seen", busy_seen, 1'b0);
    check("idle_ferr_cnt", ferr_cnt, 0);
    check("idle_ovr_cnt", ovr_cnt, 0);

    // Pop while empty is ignored.
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    @(negedge clk);
    check("pop_empty_ignored", rx_empty, 1'b1);

    // Table-driven frames at nominal baud.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, BIT_CLKS);
      model_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) repeat (320) @(negedge clk);
      $display("vec %0d: data=0x%02h stop=%0b rx_empty=%0b rx_data=0x%02h", i, vecs[i].data,
               vecs[i].stop, rx_empty, rx_data);
      check("vec_busy_during_frame", busy_seen, 1'b1);
      check("vec_ferr_cnt", ferr_cnt, exp_ferr);
      check("vec_ferr_width", ferr_wide, 0);
      if (vecs[i].exp_push) begin
        check_range("vec_push_latency", int'(fall_cyc - start_cyc), LAT_LO, LAT_HI);
        check("vec_data", rx_data, vecs[i].data);
        do_pop("vec_pop");
      end else begin
        check("vec_no_push", rx_empty, 1'b1);
      end
    end

    // Glitch shorter than half a bit.
    rx = 1'b0;
    t0 = cyc;
    repeat (40) @(negedge clk);
    check("glitch_busy", rx_busy, 1'b1);
    rx = 1'b1;
    while (rx_busy === 1'b1 && (cyc - t0) < 300) @(negedge clk);
    // 8 ticks of start check after detection, detection itself up to 2 + DIV clocks late.
    check_range("glitch_release", int'(cyc - t0), 41, 93);
    repeat (200) @(negedge clk);
    $display("glitch: released after %0d clk, rx_empty=%0b", cyc - t0, rx_empty);
    check("glitch_no_push", rx_empty, 1'b1);
    check("glitch_no_ferr", ferr_cnt, exp_ferr);

    // Overflow: 17 back-to-back bytes, no pop.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, BIT_CLKS);
      model_frame(8'(i), 1'b1);
      $display("ovf byte 0x%02h: rx_full=%0b ovr_cnt=%0d", i, rx_full, ovr_cnt);
      if (i == 14) check("ovf_not_full_15", rx_full, 1'b0);
      if (i == 15) check("ovf_full_16", rx_full, 1'b1);
    end
    check("ovf_overrun_cnt", ovr_cnt, exp_ovr);
    check("ovf_overrun_width", ovr_wide, 0);
    check("ovf_still_full", rx_full, 1'b1);
    for (int i = 0; i < 16; i++) do_pop("ovf_pop");
    check("ovf_drained", rx_empty, 1'b1);

    // Reset in the middle of data bit 3 of 0x5A, with one byte already buffered.
    send_frame(8'h77, 1'b1, BIT_CLKS);
    model_frame(8'h77, 1'b1);
    check("prerst_nonempty", rx_empty, 1'b0);
    d = 8'h5A;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    repeat (320) @(negedge clk);
    $display("midrst: rx_empty=%0b rx_busy=%0b", rx_empty, rx_busy);
    check("midrst_empty", rx_empty, 1'b1);
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_no_ferr", ferr_cnt, exp_ferr);
    check("midrst_no_ovr", ovr_cnt, exp_ovr);
    send_frame(8'h5A, 1'b1, BIT_CLKS);
    model_frame(8'h5A, 1'b1);
    do_pop("midrst_resend");

    // Fill with random bytes (mismatched baud for most), last fill frame at nominal rate.
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      pick_blen = (i < 15) ? rand_blen() : BIT_CLKS;
      send_frame(d, 1'b1, pick_blen);
      model_frame(d, 1'b1);
      $display("fill %0d: data=0x%02h blen=%0d rx_full=%0b", i, d, pick_blen, rx_full);
    end
    check("fill_full", rx_full, 1'b1);
    off = int'(full_cyc - start_cyc);
    check_range("fill_push_latency", off, LAT_LO, LAT_HI);
    if (off < LAT_LO || off > LAT_HI) off = (LAT_LO + LAT_HI) / 2;

    // Same tick phase as the previous frame, so the write lands at the same offset: pop on it.
    d = 8'($urandom);
    fork
      send_frame(d, 1'b1, BIT_CLKS);
      begin
        repeat (off - 1) @(negedge clk);
        check("coll_head", rx_data, exp_q[0]);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(d);
    $display("collision: data=0x%02h rx_full=%0b ovr_cnt=%0d", d, rx_full, ovr_cnt);
    check("coll_no_overrun", ovr_cnt, exp_ovr);
    check("coll_still_full", rx_full, 1'b1);
    for (int i = 0; i < 16; i++) do_pop("coll_pop");
    check("coll_drained", rx_empty, 1'b1);

    // Randomized frames: random data, stop bit and baud error, random pops.
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pick_blen = stop ? rand_blen() : BIT_CLKS;
      send_frame(d, stop, pick_blen);
      model_frame(d, stop);
      if (!stop) repeat (320) @(negedge clk);
      else repeat ($urandom_range(0, 30)) @(negedge clk);
      $display("rand %0d: data=0x%02h stop=%0b blen=%0d ferr_cnt=%0d", k, d, stop, pick_blen,
               ferr_cnt);
      check("rand_ferr_cnt", ferr_cnt, exp_ferr);
      check("rand_ferr_width", ferr_wide, 0);
      check("rand_empty", rx_empty, (exp_q.size() == 0));
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) do_pop("rand_pop");
    end
    while (exp_q.size() > 0) do_pop("final_pop");
    check("final_empty", rx_empty, 1'b1);
    check("final_ovr_cnt", ovr_cnt, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
